// File: rtl/tdm_demux_4x4_pkg.sv
// Shared constants and types for the 4-bank TDM lane demultiplexer.
package demux_pkg;

  localparam int NBANK = 4;

  typedef logic [1:0] bank_idx_t;

  typedef enum logic [1:0] {
    BANK_A = 2'd0,
    BANK_B = 2'd1,
    BANK_C = 2'd2,
    BANK_D = 2'd3
  } bank_e;

  function automatic bank_idx_t next_slot(input bank_idx_t cur);
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_demux_4x4_if.sv
// Lane-side and consumer-side signals of the TDM demultiplexer.
interface tdm_demux_4x4_if #(
  parameter int DW = 4
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          mode;
  logic          sync;
  logic          out_ack;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [DW-1:0] out_c;
  logic [DW-1:0] out_d;
  logic [3:0]    out_valid;
  logic [3:0]    overrun;
  logic          frame_done;
  logic [1:0]    slot;

  modport master (
    output in_valid, in_data, in_sel, mode, sync, out_ack,
    input  out_a, out_b, out_c, out_d, out_valid, overrun, frame_done, slot
  );

  modport slave (
    input  in_valid, in_data, in_sel, mode, sync, out_ack,
    output out_a, out_b, out_c, out_d, out_valid, overrun, frame_done, slot
  );
endinterface

// File: rtl/tdm_demux_4x4_bank.sv
// One output bank: data register plus written-since-ack and sticky overrun flags.
module demux_bank #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          ack,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          valid_nxt,
  output logic          overrun
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    // A write in the ack cycle lands after the clear, so it never counts as overrun.
    if (wr_en) begin
      data_d  = wr_data;
      valid_d = 1'b1;
      if (valid_q && !ack) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign valid_nxt = valid_d;
  assign overrun   = overrun_q;

endmodule

// File: rtl/tdm_demux_4x4.sv
// Steers one lane word per cycle into banks A..D by explicit select or round-robin slot.
module tdm_demux_4x4
  import demux_pkg::*;
#(
  parameter int DW = 4
) (
  input logic             clk,
  input logic             rst_n,
  tdm_demux_4x4_if.slave  bus
);

  bank_idx_t         target;
  bank_idx_t         slot_q, slot_d;
  logic              frame_done_q, frame_done_d;
  logic [NBANK-1:0]  wr_en;
  logic [NBANK-1:0]  bank_valid;
  logic [NBANK-1:0]  bank_valid_nxt;
  logic [NBANK-1:0]  bank_overrun;
  logic [DW-1:0]     bank_data [NBANK];

  always_comb begin
    if (bus.mode) target = bus.sync ? bank_idx_t'(BANK_A) : slot_q;
    else          target = bus.in_sel;
  end

  always_comb begin
    slot_d = slot_q;
    if (bus.mode && bus.in_valid) slot_d = next_slot(target);
    else if (bus.sync)            slot_d = bank_idx_t'(BANK_A);
  end

  // Pulse only on the transition into all-valid, so it re-arms after any ack.
  always_comb begin
    frame_done_d = (&bank_valid_nxt) && !(&bank_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      frame_done_q <= frame_done_d;
    end
  end

  for (genvar i = 0; i < NBANK; i++) begin : g_bank
    assign wr_en[i] = bus.in_valid && (target == bank_idx_t'(i));

    demux_bank #(.DW(DW)) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en[i]),
      .wr_data   (bus.in_data),
      .ack       (bus.out_ack),
      .data      (bank_data[i]),
      .valid     (bank_valid[i]),
      .valid_nxt (bank_valid_nxt[i]),
      .overrun   (bank_overrun[i])
    );
  end

  assign bus.out_a      = bank_data[BANK_A];
  assign bus.out_b      = bank_data[BANK_B];
  assign bus.out_c      = bank_data[BANK_C];
  assign bus.out_d      = bank_data[BANK_D];
  assign bus.out_valid  = bank_valid;
  assign bus.overrun    = bank_overrun;
  assign bus.frame_done = frame_done_q;
  assign bus.slot       = slot_q;

endmodule
